// File: rtl/sparse_expander_if.sv
// Stream interface for sparse_expander: compacted pair beats in, dense vector out.
interface sparse_expander_if #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 32,
  parameter int LANES      = 4
);
  localparam int AW = $clog2(NUM_INPUTS);
  localparam int CW = $clog2(LANES) + 1;
  localparam int NW = AW + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data  [LANES-1:0];
  logic [AW-1:0]    in_addr  [LANES-1:0];
  logic [CW-1:0]    in_count;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_matrix [NUM_INPUTS-1:0];
  logic [NW-1:0]    out_nnz;
  logic             out_dup;

  // Expander side: consumes pair beats, produces the dense vector.
  modport slave (
    input  in_valid, in_data, in_addr, in_count, in_last, out_ready,
    output in_ready, out_valid, out_matrix, out_nnz, out_dup
  );

  // Source/consumer side: offers pair beats, takes the dense vector.
  modport master (
    output in_valid, in_data, in_addr, in_count, in_last, out_ready,
    input  in_ready, out_valid, out_matrix, out_nnz, out_dup
  );
endinterface

// File: rtl/sparse_expander.sv
// sparse_expander: scatters LANES-wide (data, index) beats into a zeroed
// dense buffer and presents it, with distinct-index count and duplicate flag,
// once the last beat has been taken.

// One dense buffer element. Scans lanes low to high so the highest matching
// lane wins; flags a duplicate when the slot was already occupied or a lower
// lane in the same beat already hit it.
module sparse_expander_slot #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 32,
  parameter int LANES      = 4,
  parameter int IDX        = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [LANES-1:0]              lane_en,
  input  logic [$clog2(NUM_INPUTS)-1:0] lane_addr [LANES-1:0],
  input  logic [WIDTH-1:0]              lane_data [LANES-1:0],
  output logic [WIDTH-1:0]              q,
  output logic                          occ,
  output logic                          dup_hit
);
  localparam int AW = $clog2(NUM_INPUTS);

  logic             hit;
  logic [WIDTH-1:0] wdata;

  // Lane match: later (higher) lanes override earlier ones.
  always_comb begin
    hit     = 1'b0;
    dup_hit = 1'b0;
    wdata   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en[k] && (lane_addr[k] == AW'(IDX))) begin
        if (hit || occ) dup_hit = 1'b1;
        hit   = 1'b1;
        wdata = lane_data[k];
      end
    end
  end

  // Element storage; cleared on reset and on output handshake.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= '0;
      occ <= 1'b0;
    end else if (hit) begin
      q   <= wdata;
      occ <= 1'b1;
    end
  end
endmodule

module sparse_expander #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 32,
  parameter int LANES      = 4
) (
  input  logic            clk,
  input  logic            rst,
  sparse_expander_if.slave io
);
  localparam int AW = $clog2(NUM_INPUTS);
  localparam int CW = $clog2(LANES) + 1;
  localparam int NW = AW + 1;

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  accept;
  logic                  clr;
  logic [CW-1:0]         cnt_clamp;
  logic [LANES-1:0]      lane_en;
  logic [WIDTH-1:0]      buf_q [NUM_INPUTS-1:0];
  logic [NUM_INPUTS-1:0] occ;
  logic [NUM_INPUTS-1:0] dup_hit;
  logic                  dup_q;
  logic [NW-1:0]         nnz;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next state: leave FILL on an accepted last beat, leave DRAIN on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && io.in_last) state_nxt = DRAIN;
      DRAIN:   if (clr)                  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Handshake outputs; both held low while reset is asserted.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      FILL:    in_ready_c  = !rst;
      DRAIN:   out_valid_c = !rst;
      default: ;
    endcase
  end

  assign accept = io.in_valid && in_ready_c;
  assign clr    = out_valid_c && io.out_ready;

  // Oversized counts are clamped so only physical lanes participate.
  always_comb begin
    cnt_clamp = (io.in_count > CW'(LANES)) ? CW'(LANES) : io.in_count;
  end

  // Lanes beyond the count are masked out, address included.
  always_comb begin
    lane_en = '0;
    for (int k = 0; k < LANES; k++)
      lane_en[k] = accept && (CW'(k) < cnt_clamp);
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_slot
    sparse_expander_slot #(
      .WIDTH      (WIDTH),
      .NUM_INPUTS (NUM_INPUTS),
      .LANES      (LANES),
      .IDX        (i)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .lane_en   (lane_en),
      .lane_addr (io.in_addr),
      .lane_data (io.in_data),
      .q         (buf_q[i]),
      .occ       (occ[i]),
      .dup_hit   (dup_hit[i])
    );
  end

  // Sticky duplicate flag for the vector being assembled.
  always_ff @(posedge clk) begin
    if (rst || clr)   dup_q <= 1'b0;
    else if (|dup_hit) dup_q <= 1'b1;
  end

  // Distinct-index count from registered occupancy only.
  always_comb begin
    nnz = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      nnz = nnz + NW'(occ[i]);
  end

  // Output drive; forced to zero while reset is asserted.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      io.out_matrix[i] = rst ? '0 : buf_q[i];
    io.out_nnz   = rst ? '0 : nnz;
    io.out_dup   = !rst && dup_q;
    io.out_valid = out_valid_c;
    io.in_ready  = in_ready_c;
  end
endmodule

// File: tb/tb_sparse_expander.sv
// Directed bench for sparse_expander (LANES=4, NUM_INPUTS=32, WIDTH=32).
module tb_sparse_expander;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] bd [4];
  logic [4:0]  ba [4];
  logic [31:0] em [32];

  sparse_expander_if #(.WIDTH(32), .NUM_INPUTS(32), .LANES(4)) ifc ();

  sparse_expander #(.WIDTH(32), .NUM_INPUTS(32), .LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  always #5 clk = ~clk;

  // Index of first element differing from em[], or -1.
  function automatic int first_diff();
    for (int i = 0; i < 32; i++)
      if (ifc.out_matrix[i] !== em[i]) return i;
    return -1;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) em[i] = '0;
  endtask

  // Present one beat from bd/ba for one clock; called #1 after a rising edge.
  task automatic drive_beat(input int cnt, input bit last);
    ifc.in_valid = 1'b1;
    ifc.in_count = 3'(cnt);
    ifc.in_last  = last;
    for (int k = 0; k < 4; k++) begin
      ifc.in_data[k] = bd[k];
      ifc.in_addr[k] = ba[k];
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic handshake();
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int d;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL reset.in_ready_during got=%0b exp=0", ifc.in_ready); end
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset.out_valid_during got=%0b exp=0", ifc.out_valid); end
    rst = 1'b0;
    #1;
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL reset.in_ready_after got=%0b exp=1", ifc.in_ready); end
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset.out_valid_after got=%0b exp=0", ifc.out_valid); end
    total++; if (ifc.out_nnz !== 6'd0) begin bad++; $display("FAIL reset.nnz got=%0d exp=0", ifc.out_nnz); end
    total++; if (ifc.out_dup !== 1'b0) begin bad++; $display("FAIL reset.dup got=%0b exp=0", ifc.out_dup); end
    clear_exp();
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL reset.matrix idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    @(posedge clk); #1;
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset.idle_valid got=%0b exp=0", ifc.out_valid); end
  endtask

  task automatic test_single();
    int d;
    bd = '{32'hA, 32'hB, 32'hC, 32'h77};
    ba = '{5'd2, 5'd7, 5'd31, 5'd5};   // lane 3 unused, must not land at 5
    drive_beat(3, 1'b1);
    clear_exp(); em[2] = 32'hA; em[7] = 32'hB; em[31] = 32'hC;
    total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL single.valid got=%0b exp=1", ifc.out_valid); end
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL single.in_ready got=%0b exp=0", ifc.in_ready); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL single.matrix idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    total++; if (ifc.out_nnz !== 6'd3) begin bad++; $display("FAIL single.nnz got=%0d exp=3", ifc.out_nnz); end
    total++; if (ifc.out_dup !== 1'b0) begin bad++; $display("FAIL single.dup got=%0b exp=0", ifc.out_dup); end
    handshake();
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL single.valid_after got=%0b exp=0", ifc.out_valid); end
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL single.ready_after got=%0b exp=1", ifc.in_ready); end
  endtask

  task automatic test_stall();
    int d;
    clear_exp();
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++) begin
        ba[k] = 5'(4*b + k);
        bd[k] = 32'(4*b + k + 1);
        em[4*b + k] = 32'(4*b + k + 1);
      end
      drive_beat(4, b == 7);
    end
    total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL stall.valid got=%0b exp=1", ifc.out_valid); end
    total++; if (ifc.out_nnz !== 6'd32) begin bad++; $display("FAIL stall.nnz got=%0d exp=32", ifc.out_nnz); end
    total++; if (ifc.out_dup !== 1'b0) begin bad++; $display("FAIL stall.dup got=%0b exp=0", ifc.out_dup); end
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL stall.ramp idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    // Source holds a beat for index 0 during the stall; it must wait.
    ifc.in_valid = 1'b1; ifc.in_count = 3'd1; ifc.in_last = 1'b0;
    ifc.in_data[0] = 32'hDEAD; ifc.in_addr[0] = 5'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      d = first_diff();
      total++; if (d >= 0) begin bad++; $display("FAIL stall.hold c=%0d idx=%0d got=%h exp=%h", c, d, ifc.out_matrix[d], em[d]); end
      total++; if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1 || ifc.out_nnz !== 6'd32) begin
        bad++; $display("FAIL stall.ctl c=%0d ready=%0b valid=%0b nnz=%0d exp ready=0 valid=1 nnz=32", c, ifc.in_ready, ifc.out_valid, ifc.out_nnz);
      end
    end
    handshake();
    clear_exp();
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL stall.cleared idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    total++; if (ifc.in_ready !== 1'b1 || ifc.out_nnz !== 6'd0) begin
      bad++; $display("FAIL stall.refill ready=%0b nnz=%0d exp ready=1 nnz=0", ifc.in_ready, ifc.out_nnz);
    end
    @(posedge clk); #1;   // held beat is taken here
    ifc.in_valid = 1'b0;
    drive_beat(0, 1'b1);
    em[0] = 32'hDEAD;
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL stall.held_beat idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    total++; if (ifc.out_nnz !== 6'd1) begin bad++; $display("FAIL stall.held_nnz got=%0d exp=1", ifc.out_nnz); end
    handshake();
  endtask

  task automatic test_dup();
    int d;
    bd = '{32'd1, 32'd2, 32'd0, 32'd0};
    ba = '{5'd5, 5'd5, 5'd0, 5'd0};
    drive_beat(2, 1'b1);
    clear_exp(); em[5] = 32'd2;
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL dup.same_beat idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    total++; if (ifc.out_nnz !== 6'd1) begin bad++; $display("FAIL dup.same_nnz got=%0d exp=1", ifc.out_nnz); end
    total++; if (ifc.out_dup !== 1'b1) begin bad++; $display("FAIL dup.same_flag got=%0b exp=1", ifc.out_dup); end
    handshake();
    bd[0] = 32'd3; ba[0] = 5'd9;
    drive_beat(1, 1'b0);
    bd[0] = 32'd4; ba[0] = 5'd9;
    drive_beat(1, 1'b1);
    clear_exp(); em[9] = 32'd4;
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL dup.cross_beat idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    total++; if (ifc.out_nnz !== 6'd1) begin bad++; $display("FAIL dup.cross_nnz got=%0d exp=1", ifc.out_nnz); end
    total++; if (ifc.out_dup !== 1'b1) begin bad++; $display("FAIL dup.cross_flag got=%0b exp=1", ifc.out_dup); end
    handshake();
  endtask

  task automatic test_count_edges();
    int d;
    bd = '{32'h55, 32'h66, 32'h77, 32'h88};
    ba = '{5'd1, 5'd2, 5'd3, 5'd4};
    drive_beat(0, 1'b1);
    clear_exp();
    d = first_diff();
    total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL count0.valid got=%0b exp=1", ifc.out_valid); end
    total++; if (d >= 0) begin bad++; $display("FAIL count0.matrix idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    total++; if (ifc.out_nnz !== 6'd0 || ifc.out_dup !== 1'b0) begin
      bad++; $display("FAIL count0.nnz_dup nnz=%0d dup=%0b exp nnz=0 dup=0", ifc.out_nnz, ifc.out_dup);
    end
    handshake();
    bd = '{32'h11, 32'h22, 32'h33, 32'h0};   // zero data still occupies
    ba = '{5'd1, 5'd2, 5'd3, 5'd4};
    drive_beat(7, 1'b1);
    clear_exp(); em[1] = 32'h11; em[2] = 32'h22; em[3] = 32'h33;
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL count7.matrix idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    total++; if (ifc.out_nnz !== 6'd4) begin bad++; $display("FAIL count7.nnz got=%0d exp=4", ifc.out_nnz); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int d;
    bd = '{32'd1, 32'd0, 32'd0, 32'd0}; ba = '{5'd10, 5'd0, 5'd0, 5'd0};
    drive_beat(1, 1'b0);
    bd[0] = 32'd2; ba[0] = 5'd11;
    drive_beat(1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid.valid_during got=%0b exp=0", ifc.out_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (ifc.out_valid !== 1'b0 || ifc.out_nnz !== 6'd0) begin
      bad++; $display("FAIL rstmid.after valid=%0b nnz=%0d exp valid=0 nnz=0", ifc.out_valid, ifc.out_nnz);
    end
    bd[0] = 32'hF; ba[0] = 5'd0;
    drive_beat(1, 1'b1);
    clear_exp(); em[0] = 32'hF;
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL rstmid.matrix idx=%0d got=%h exp=%h", d, ifc.out_matrix[d], em[d]); end
    total++; if (ifc.out_nnz !== 6'd1 || ifc.out_dup !== 1'b0) begin
      bad++; $display("FAIL rstmid.nnz_dup nnz=%0d dup=%0b exp nnz=1 dup=0", ifc.out_nnz, ifc.out_dup);
    end
    // Reset while a vector is pending in DRAIN drops it.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.out_nnz !== 6'd0) begin
      bad++; $display("FAIL rstdrain valid=%0b ready=%0b nnz=%0d exp valid=0 ready=1 nnz=0", ifc.out_valid, ifc.in_ready, ifc.out_nnz);
    end
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_count  = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ifc.in_data[k] = '0;
      ifc.in_addr[k] = '0;
    end
    test_reset();
    test_single();
    test_stall();
    test_dup();
    test_count_edges();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
